prog_sequencer: RTL and testbench
=================================

# prog_sequencer

Program sequencer for the 9-bit single-cycle core. It owns the program counter, runs the Req/Ack start/done handshake with the testbench, and resolves branch and jump targets. Targets come either from a 32-entry branch target LUT or from a PC-relative offset. It sits between the instruction ROM, which is addressed by `ProgCtr`, and the control decoder, whose `BranchEn`, `BranchAccept` and `Jump` outputs feed this block. `Running` gates all datapath writes.

## Interface
- `PC_W`, 10: program counter width; ROM depth is 2^PC_W words.
- `START_PC`, 0: PC loaded when a run starts.
- `HALT_WORD`, 9'h1FF: instruction encoding that ends a run.
- `Clk` input, 1: the single clock; all state updates on its rising edge.
- `Reset` input, 1: synchronous, active-high.
- `Req` input, 1: start request from the testbench; level-sampled.
- `Instruction` input, 9: ROM output at `ProgCtr`, combinational same cycle.
- `BranchEn` input, 1: the current instruction is a branch.
- `BranchAccept` input, 1: the branch condition holds.
- `Jump` input, 1: unconditional transfer.
- `Stall` input, 1: hold the current instruction for one more cycle.
- `lut_we` input, 1: branch LUT write strobe.
- `lut_waddr` input, 5: LUT write index.
- `lut_wdata` input, PC_W: LUT write data (absolute target).
- `ProgCtr` output, PC_W: registered instruction address.
- `Running` output, 1: high in RUN only; datapath write-enable gate.
- `Ack` output, 1: run complete; held high in DONE.
- `Overflow` output, 1: the run ended by PC wrap rather than HALT_WORD.
- `CycleCount` output, 16: cycles spent in RUN, saturating.

## Operation
- **States:** IDLE, RUN, DONE. `Reset` forces IDLE, `ProgCtr=0`, `Ack=0`, `Overflow=0`, `CycleCount=0`, and clears all LUT entries to 0.
- **IDLE:**
  - `Req=1` moves to RUN with `ProgCtr<=START_PC`, `CycleCount<=0`, `Overflow<=0`.
  - LUT writes are accepted only in IDLE. `lut_we` in RUN or DONE is ignored.
- **RUN, evaluated each cycle in priority order:**
  1. `Stall=1`: PC holds; no other action.
  2. `Instruction==HALT_WORD`: go to DONE; PC holds.
  3. `Jump=1`, or `BranchEn=1` with `BranchAccept=1`: `ProgCtr<=target`.
  4. Otherwise, `ProgCtr<=ProgCtr+1`.
- **Target index:** `Instruction[4:0]` selects the target (see Configuration).
- **Sequential increment at PC = 2^PC_W−1:** go to DONE and set `Overflow=1`; PC holds at the maximum. A taken branch at the maximum PC is not overflow.
- **CycleCount:** increments every RUN cycle, including stall cycles and the cycle that detects HALT_WORD. It saturates at 16'hFFFF.
- **Req during RUN** is ignored.
- **DONE:**
  - `Ack=1` is held.
  - `Req=1` restarts directly: next state RUN, with the same loads as from IDLE, and `Ack` falls.
  - `Req=0` stays in DONE.
- **`Reset` mid-run:** returns to IDLE next edge, with no Ack pulse.

## Timing
- `ProgCtr`, `Ack`, `Running`, `Overflow` and `CycleCount` are all registered, with no combinational input-to-output path.
- The first instruction at `START_PC` executes in the first RUN cycle, one cycle after `Req` is sampled.
- A taken branch has zero penalty: the target is presented on the next cycle.
- `Ack` rises on the edge that enters DONE, so the HALT_WORD cycle has `Running=1` and the following cycle has `Ack=1`, `Running=0`.
- A LUT write in IDLE is visible to a branch in the first RUN cycle.

## Configuration
- `PROG_SEQ_BRANCH_LUT_EN` defined:
  - target = LUT[`Instruction[4:0]`] (absolute).
  - The LUT is 32×PC_W registers.
- `PROG_SEQ_BRANCH_LUT_EN` undefined:
  - target = `ProgCtr` + sign-extended `Instruction[4:0]`, a range of −16..+15, wrapping modulo 2^PC_W.
  - No LUT storage is built; the `lut_*` ports exist but are ignored.

## Test plan
- **Reset and start:** pulse `Reset`, then `Req=1`.
  - Required: `ProgCtr` walks 0,1,2,…
  - HALT_WORD at address 5 gives `Ack=1` on the cycle after `ProgCtr=5`, with `CycleCount=6`.
- **LUT branch (macro on):** in IDLE, write LUT[3]=10'd40; start; at PC 2, drive `BranchEn=1`, `BranchAccept=1`, `Instruction[4:0]=3`.
  - Required: next `ProgCtr=40`.
  - With `BranchAccept=0`, next `ProgCtr=3`.
- **Relative jump (macro off):** at PC 4, `Jump=1` with offset 5'b11110.
  - Required: next `ProgCtr=2`.
  - At PC 1020 with offset +15: next `ProgCtr=11`.
- **Stall:** hold `Stall=1` for 3 cycles at PC 7, with HALT_WORD present at PC 7.
  - Required: `ProgCtr=7` throughout and no DONE until `Stall` falls.
  - `CycleCount` still increments by 3.
- **Overflow:** a run with no halt reaching PC 1023 with sequential flow.
  - Required: DONE, `Overflow=1`, `ProgCtr=1023`.
  - Then `Req` restarts with `Overflow=0`, `ProgCtr=START_PC`.
- **Mid-run reset and ignored writes:** assert `Reset` during RUN.
  - Required: next cycle IDLE, `ProgCtr=0`, `Ack=0`.
  - A `lut_we` issued during RUN leaves the LUT unchanged.

Source files
------------

// File: rtl/prog_sequencer.sv
// Program sequencer: PC, Req/Ack run handshake, branch/jump target resolution (LUT targets with PROG_SEQ_BRANCH_LUT_EN).
// Latency: all outputs are registered; a taken branch presents its target on the next cycle.
// Backpressure: Stall holds the current instruction; Req is ignored while running.
module prog_sequencer #(
  parameter int              PC_W      = 10,
  parameter logic [PC_W-1:0] START_PC  = '0,
  parameter logic [8:0]      HALT_WORD = 9'h1FF
) (
  input  logic            Clk,
  input  logic            Reset,
  input  logic            Req,
  input  logic [8:0]      Instruction,
  input  logic            BranchEn,
  input  logic            BranchAccept,
  input  logic            Jump,
  input  logic            Stall,
  input  logic            lut_we,
  input  logic [4:0]      lut_waddr,
  input  logic [PC_W-1:0] lut_wdata,
  output logic [PC_W-1:0] ProgCtr,
  output logic            Running,
  output logic            Ack,
  output logic            Overflow,
  output logic [15:0]     CycleCount
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [PC_W-1:0] PC_MAX = '1;
  localparam logic [PC_W-1:0] PC_ONE = {{(PC_W-1){1'b0}}, 1'b1};

  logic [1:0]      state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic            ovf_q, ovf_d;
  logic [15:0]     cnt_q, cnt_d;
  logic [PC_W-1:0] target;
  logic            taken;

  assign taken = Jump | (BranchEn & BranchAccept);

`ifdef PROG_SEQ_BRANCH_LUT_EN
  logic [PC_W-1:0] lut_q [32];
  logic [PC_W-1:0] lut_d [32];

  // Table is frozen outside IDLE so a running program sees stable targets.
  always_comb begin
    lut_d = lut_q;
    if (state_q == ST_IDLE && lut_we) begin
      lut_d[lut_waddr] = lut_wdata;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < 32; i++) begin
        lut_q[i] <= '0;
      end
    end else begin
      lut_q <= lut_d;
    end
  end

  assign target = lut_q[Instruction[4:0]];
`else
  logic unused_lut;
  assign unused_lut = ^{lut_we, lut_waddr, lut_wdata};

  // Signed 5-bit offset relative to the current PC, wrapping at the ROM size.
  assign target = pc_q + {{(PC_W-5){Instruction[4]}}, Instruction[4:0]};
`endif

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ovf_d   = ovf_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (Req) begin
          state_d = ST_RUN;
          pc_d    = START_PC;
          ovf_d   = 1'b0;
          cnt_d   = '0;
        end
      end
      ST_RUN: begin
        if (cnt_q != 16'hFFFF) begin
          cnt_d = cnt_q + 16'd1;
        end
        if (!Stall) begin
          if (Instruction == HALT_WORD) begin
            state_d = ST_DONE;
          end else if (taken) begin
            pc_d = target;
          end else if (pc_q == PC_MAX) begin
            state_d = ST_DONE;
            ovf_d   = 1'b1;
          end else begin
            pc_d = pc_q + PC_ONE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= ST_IDLE;
      pc_q    <= '0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
    end
  end

  assign ProgCtr    = pc_q;
  assign Running    = (state_q == ST_RUN);
  assign Ack        = (state_q == ST_DONE);
  assign Overflow   = ovf_q;
  assign CycleCount = cnt_q;

endmodule

// File: tb/tb_prog_sequencer.sv
// Scoreboarded random/directed bench for prog_sequencer against a behavioural model of the run rules.
module tb_prog_sequencer;

  localparam int         START = 0;
  localparam logic [8:0] HALT  = 9'h1FF;

  logic        Clk = 1'b0;
  logic        Reset = 1'b0, Req = 1'b0, BranchEn = 1'b0, BranchAccept = 1'b0;
  logic        Jump = 1'b0, Stall = 1'b0, lut_we = 1'b0;
  logic [8:0]  Instruction = '0;
  logic [4:0]  lut_waddr = '0;
  logic [9:0]  lut_wdata = '0;
  logic [9:0]  ProgCtr;
  logic        Running, Ack, Overflow;
  logic [15:0] CycleCount;

  prog_sequencer #(.PC_W(10), .START_PC(10'd0), .HALT_WORD(9'h1FF)) dut (
    .Clk(Clk), .Reset(Reset), .Req(Req), .Instruction(Instruction),
    .BranchEn(BranchEn), .BranchAccept(BranchAccept), .Jump(Jump), .Stall(Stall),
    .lut_we(lut_we), .lut_waddr(lut_waddr), .lut_wdata(lut_wdata),
    .ProgCtr(ProgCtr), .Running(Running), .Ack(Ack), .Overflow(Overflow),
    .CycleCount(CycleCount)
  );

  always #5 Clk = ~Clk;

  typedef struct packed {
    logic [9:0]  pc;
    logic        run;
    logic        ack;
    logic        ovf;
    logic [15:0] cnt;
  } obs_t;

  obs_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  logic [8:0] rom [1024];

  // Reference model: phase flags, PC, overflow flag, saturating counter, target table.
  bit m_run  = 0;
  bit m_done = 0;
  int m_pc   = 0;
  bit m_ovf  = 0;
  int m_cnt  = 0;
  int m_lut [32];

  function automatic int target_of(input logic [8:0] instr);
    int idx;
    int off;
    idx = int'(instr[4:0]);
`ifdef PROG_SEQ_BRANCH_LUT_EN
    target_of = m_lut[idx];
`else
    off = (idx >= 16) ? idx - 32 : idx;
    target_of = (m_pc + off + 1024) % 1024;
`endif
  endfunction

  task automatic model_step(input bit r, rq, be, ba, j, st, lwe, input int la, ld,
                            input logic [8:0] instr);
    if (r) begin
      m_run = 0; m_done = 0; m_pc = 0; m_ovf = 0; m_cnt = 0;
      for (int i = 0; i < 32; i++) m_lut[i] = 0;
    end else if (m_run) begin
      if (m_cnt < 65535) m_cnt = m_cnt + 1;
      if (!st) begin
        if (instr == HALT) begin
          m_run = 0; m_done = 1;
        end else if (j || (be && ba)) begin
          m_pc = target_of(instr);
        end else if (m_pc == 1023) begin
          m_run = 0; m_done = 1; m_ovf = 1;
        end else begin
          m_pc = m_pc + 1;
        end
      end
    end else begin
      if (!m_done && lwe) m_lut[la] = ld;
      if (rq) begin
        m_run = 1; m_done = 0; m_pc = START; m_cnt = 0; m_ovf = 0;
      end
    end
  endtask

  task automatic cycle(input bit r, rq, be, ba, j, st, lwe, input int la, ld);
    obs_t e;
    logic [8:0] instr;
    @(negedge Clk);
    instr        = rom[m_pc];
    Reset        = r;
    Req          = rq;
    BranchEn     = be;
    BranchAccept = ba;
    Jump         = j;
    Stall        = st;
    lut_we       = lwe;
    lut_waddr    = la[4:0];
    lut_wdata    = ld[9:0];
    Instruction  = instr;
    model_step(r, rq, be, ba, j, st, lwe, la, ld, instr);
    e.pc  = m_pc[9:0];
    e.run = m_run;
    e.ack = m_done;
    e.ovf = m_ovf;
    e.cnt = m_cnt[15:0];
    exp_q.push_back(e);
  endtask

  task automatic step(input bit rq, be, ba, j, st);
    cycle(1'b0, rq, be, ba, j, st, 1'b0, 0, 0);
  endtask

  task automatic expect_ack(input string name);
    @(posedge Clk);
    #2;
    n_checks++;
    if (Ack !== 1'b1) begin
      n_fail++;
      $display("FAIL %s: Ack=%b after run bound, required 1 (pc=%0d)", name, Ack, ProgCtr);
    end
  endtask

  task automatic fill_rom(input int halt_mod);
    for (int i = 0; i < 1024; i++) begin
      if (halt_mod > 0 && $urandom_range(halt_mod - 1, 0) == 0) rom[i] = HALT;
      else rom[i] = 9'($urandom_range(510, 0));
    end
  endtask

  // Monitor: one expected observation per modelled clock edge.
  initial begin
    obs_t e, got;
    forever begin
      @(posedge Clk);
      #1;
      if (exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        got = {ProgCtr, Running, Ack, Overflow, CycleCount};
        n_checks++;
        if (got !== e) begin
          n_fail++;
          $display("FAIL obs @%0t: got pc=%0d run=%b ack=%b ovf=%b cnt=%0d, exp pc=%0d run=%b ack=%b ovf=%b cnt=%0d",
                   $time, got.pc, got.run, got.ack, got.ovf, got.cnt,
                   e.pc, e.run, e.ack, e.ovf, e.cnt);
        end
      end
    end
  end

  initial begin
    bit once;
    int ns;

    // Reset and first run: halt at address 5
    fill_rom(0);
    rom[5] = HALT;
    cycle(1, 0, 0, 0, 0, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    for (int k = 0; k < 20 && m_run; k++) step(0, 0, 0, 0, 0);
    expect_ack("halt5");
    step(0, 0, 0, 0, 0);

    // Branch taken / not taken via index 3
    cycle(1, 0, 0, 0, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 1, 3, 40);
    fill_rom(0);
    rom[2] = 9'd3; rom[5] = HALT; rom[40] = HALT;
    step(1, 0, 0, 0, 0);
    for (int k = 0; k < 60 && m_run; k++) step(0, m_pc == 2, m_pc == 2, 0, 0);
    expect_ack("br_taken");
    step(1, 0, 0, 0, 0);
    for (int k = 0; k < 60 && m_run; k++) step(0, m_pc == 2, 0, 0, 0);
    expect_ack("br_not_taken");

    // Jump with offset -2 at PC 4
    rom[4] = 9'b0000_11110;
    once = 0;
    step(1, 0, 0, 0, 0);
    for (int k = 0; k < 200 && m_run; k++) begin
      if (m_pc == 4 && !once) begin
        once = 1;
        step(0, 0, 0, 1, 0);
      end else step(0, 0, 0, 0, 0);
    end
    expect_ack("jump_back");

    // Jump +15 at PC 1020 wraps to 11
    fill_rom(0);
    rom[2] = 9'd3; rom[1020] = 9'd15; rom[11] = HALT;
    once = 0;
    step(1, 0, 0, 0, 0);
    for (int k = 0; k < 2600 && m_run; k++) begin
      if (m_pc == 1020 && !once) begin
        once = 1;
        step(0, 0, 0, 1, 0);
      end else step(0, 0, 0, 0, 0);
    end
    expect_ack("jump_wrap");

    // Three stall cycles on a HALT at PC 7
    fill_rom(0);
    rom[2] = 9'd3; rom[7] = HALT;
    ns = 0;
    step(1, 0, 0, 0, 0);
    for (int k = 0; k < 60 && m_run; k++) begin
      if (m_pc == 7 && ns < 3) begin
        ns++;
        step(0, 0, 0, 0, 1);
      end else step(0, 0, 0, 0, 0);
    end
    expect_ack("stall_halt");

    // Sequential overflow, with ignored LUT write and Req while running
    fill_rom(0);
    rom[2] = 9'd3;
    step(1, 0, 0, 0, 0);
    for (int k = 0; k < 1200 && m_run; k++) cycle(0, k == 20, 0, 0, 0, 0, k == 10, 3, 77);
    expect_ack("overflow");
    cycle(0, 0, 0, 0, 0, 0, 1, 3, 77);
    rom[5] = HALT; rom[40] = HALT;
    step(1, 0, 0, 0, 0);
    for (int k = 0; k < 60 && m_run; k++) step(0, m_pc == 2, m_pc == 2, 0, 0);
    expect_ack("lut_kept");

    // Reset in the middle of a run
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);

    // Randomised runs
    for (int it = 0; it < 40; it++) begin
      if ($urandom_range(3, 0) == 0) cycle(1, 0, 0, 0, 0, 0, 0, 0, 0);
      repeat ($urandom_range(4, 0))
        cycle(0, 0, 0, 0, 0, 0, 1, int'($urandom_range(31, 0)), int'($urandom_range(1023, 0)));
      fill_rom(24);
      step(1, 0, 0, 0, 0);
      for (int k = 0; k < 400 && m_run; k++)
        cycle($urandom_range(299, 0) == 0, $urandom_range(9, 0) == 0,
              $urandom_range(3, 0) == 0, $urandom_range(1, 0) == 1,
              $urandom_range(7, 0) == 0, $urandom_range(5, 0) == 0,
              $urandom_range(9, 0) == 0, int'($urandom_range(31, 0)),
              int'($urandom_range(1023, 0)));
      step(0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0);
    end

    repeat (3) @(posedge Clk);
    #2;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d observations left unchecked, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
